// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared RV32I memory constants, funct3 codes and responder FSM states
package rv32_mem_pkg;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [31:0] DMEM_BASE = 32'h0020_0000;
  localparam logic [31:0] DMEM_END = 32'h0024_FFFF;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: word RAM with byte enables, one synchronous read port and one write port
module dmem_byte_ram #(
  parameter int DEPTH = 81920,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I load/store responder with fixed latency, fault checks and byte-lane steering
module dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int DEPTH_WORDS = 81920,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic we_q, err_q;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic [31:0] off, wlane, lane, ram_rdata;
  logic [3:0] be;
  logic [7:0] b;
  logic [15:0] h;
  logic acc, oor, mis, ill, fault;
  always_comb begin
    acc = req_valid && state == IDLE;
    off = req_addr - BASE_ADDR;
    oor = req_addr < BASE_ADDR || off >= 32'(4 * DEPTH_WORDS);
    mis = (req_funct3 == F3_H || req_funct3 == F3_HU) ? req_addr[0] : req_funct3 == F3_W && req_addr[1:0] != 2'b00;
    ill = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (req_we && req_funct3[2]);
    fault = oor || mis || ill;
    be = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] : req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    wlane = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} : req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    b = ram_rdata[{a_q, 3'b000} +: 8];
    h = ram_rdata[{a_q[1], 4'b0000} +: 16];
    lane = f3_q == F3_B ? {{24{b[7]}}, b} : f3_q == F3_H ? {{16{h[15]}}, h} : f3_q == F3_BU ? {24'h0, b} : f3_q == F3_HU ? {16'h0, h} : ram_rdata;
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_err = rsp_valid && err_q;
    rsp_rdata = rsp_valid && !err_q && !we_q ? lane : 32'h0;
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: if (acc) begin
        state_d = LATENCY == 1 ? RESP : WAIT;
        cnt_d = CW'(LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt == CW'(1) ? RESP : WAIT;
        cnt_d = cnt - 1'b1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_d;
    cnt <= rst ? '0 : cnt_d;
  end
  always_ff @(posedge clk)
    if (rst) begin
      we_q <= 1'b0;
      err_q <= 1'b0;
      f3_q <= F3_B;
      a_q <= 2'b00;
    end else if (acc) begin
      we_q <= req_we;
      err_q <= fault;
      f3_q <= req_funct3;
      a_q <= req_addr[1:0];
    end
  dmem_byte_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk(clk),
    .we(acc && req_we && !fault),
    .be(be),
    .waddr(off[AW+1:2]),
    .wdata(wlane),
    .re(acc && !req_we && !fault),
    .raddr(off[AW+1:2]),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-level memory model
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h0020_0000;
  localparam logic [31:0] LIMIT = 32'h0025_0000;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
  logic clk, rst;
  logic req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [2:0] req_funct3 [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  int checks = 0, errors = 0;
  bit armed = 0;
  bit busy [2];
  int k [2];
  bit exp_err [2], exp_known [2];
  logic [31:0] exp_rd [2];
  logic [7:0] mm [logic [32:0]];

  dmem_responder #(.LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return i == 0 ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_access(input int i, input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz;
    bit legal, e;
    logic [31:0] v, ones;
    logic [32:0] key;
    sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    legal = (f3 inside {B, H, W, BU, HU}) && !(we && f3[2]);
    e = !(legal && a >= BASE && a < LIMIT && (a % sz) == 0);
    exp_err[i] = e;
    exp_rd[i] = 0;
    exp_known[i] = 1;
    if (!e && we)
      for (int j = 0; j < sz; j++) begin
        key = {i[0], a + 32'(j)};
        mm[key] = wd[8*j +: 8];
      end
    if (!e && !we) begin
      v = 0;
      for (int j = 0; j < sz; j++) begin
        key = {i[0], a + 32'(j)};
        if (mm.exists(key)) v = v | (32'(mm[key]) << (8 * j));
        else exp_known[i] = 0;
      end
      ones = '1;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (ones << (8 * sz));
      exp_rd[i] = v;
    end
  endtask

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 0;
        armed = 1;
      end else if (busy[i]) begin
        if (k[i] >= lat_of(i) && rsp_ready[i]) busy[i] = 0;
        else k[i]++;
      end else if (req_valid[i]) begin
        model_access(i, req_we[i], req_funct3[i], req_addr[i], req_wdata[i]);
        busy[i] = 1;
        k[i] = 1;
      end
    end

  always @(negedge clk)
    if (armed && !rst)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("req_ready%0d", i), 32'(req_ready[i]), 32'(!busy[i]));
        chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(busy[i] && k[i] >= lat_of(i)));
        if (busy[i] && k[i] >= lat_of(i)) begin
          chk($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(exp_err[i]));
          if (exp_known[i]) chk($sformatf("rsp_rdata%0d", i), rsp_rdata[i], exp_rd[i]);
        end
      end

  task automatic txn(input int i, input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic e, output int lat);
    int n;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("req_ready_timeout", 32'(req_ready[i]), 1);
    req_valid[i] = 1;
    req_we[i] = we;
    req_funct3[i] = f3;
    req_addr[i] = a;
    req_wdata[i] = wd;
    @(posedge clk); #1;
    req_valid[i] = 0;
    req_we[i] = 1'($urandom);
    req_funct3[i] = 3'($urandom);
    req_addr[i] = $urandom;
    req_wdata[i] = $urandom;
    lat = 1;
    while (!rsp_valid[i] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid[i]) chk("rsp_valid_timeout", 32'(rsp_valid[i]), 1);
    rd = rsp_rdata[i];
    e = rsp_err[i];
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready[i] = 1;
    @(posedge clk); #1;
    rsp_ready[i] = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, d;
    logic e;
    int lat, r, i;
    logic [2:0] f3;
    for (int j = 0; j < 2; j++) begin
      req_valid[j] = 0;
      req_we[j] = 0;
      req_funct3[j] = 0;
      req_addr[j] = 0;
      req_wdata[j] = 0;
      rsp_ready[j] = 0;
    end
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int j = 0; j < 2; j++) begin
      chk("reset_req_ready", 32'(req_ready[j]), 1);
      chk("reset_rsp_valid", 32'(rsp_valid[j]), 0);
      chk("reset_rsp_rdata", rsp_rdata[j], 0);
      chk("reset_rsp_err", 32'(rsp_err[j]), 0);
    end
    for (int j = 0; j < 2; j++)
      for (int w = 0; w < 64; w++) begin
        txn(j, 1, W, BASE + 32'(4 * w), 0, 0, rd, e, lat);
        txn(j, 1, W, LIMIT - 32'h100 + 32'(4 * w), 0, 0, rd, e, lat);
      end
    txn(0, 1, W, BASE, 32'hDEADBEEF, 0, rd, e, lat);
    chk("sw_err", 32'(e), 0);
    chk("sw_latency", lat, 2);
    txn(0, 0, W, BASE, 0, 0, rd, e, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(e), 0);
    chk("lw_latency", lat, 2);
    txn(0, 1, B, BASE + 5, 32'h00000080, 0, rd, e, lat);
    txn(0, 0, B, BASE + 5, 0, 0, rd, e, lat);
    chk("lb_sign", rd, 32'hFFFFFF80);
    txn(0, 0, BU, BASE + 5, 0, 0, rd, e, lat);
    chk("lbu_zero", rd, 32'h00000080);
    txn(0, 0, W, BASE + 4, 0, 0, rd, e, lat);
    chk("lw_after_sb", rd, 32'h00008000);
    txn(0, 1, H, BASE + 3, 32'h1234, 0, rd, e, lat);
    chk("sh_misaligned_err", 32'(e), 1);
    chk("sh_misaligned_rdata", rd, 0);
    txn(0, 0, W, BASE, 0, 0, rd, e, lat);
    chk("lw_unchanged", rd, 32'hDEADBEEF);
    txn(0, 0, W, LIMIT, 0, 0, rd, e, lat);
    chk("lw_above_err", 32'(e), 1);
    txn(0, 0, W, 32'h001FFFFC, 0, 0, rd, e, lat);
    chk("lw_below_err", 32'(e), 1);
    chk("lw_below_rdata", rd, 0);
    txn(0, 0, 3'b011, BASE, 0, 0, rd, e, lat);
    chk("f3_011_err", 32'(e), 1);
    txn(0, 1, BU, BASE + 8, 32'h55, 0, rd, e, lat);
    chk("sbu_illegal_err", 32'(e), 1);
    txn(0, 0, HU, BASE + 2, 0, 3, rd, e, lat);
    chk("lhu_held_data", rd, 32'h0000DEAD);
    chk("req_ready_after_hs", 32'(req_ready[0]), 1);
    txn(0, 0, H, LIMIT - 2, 0, 0, rd, e, lat);
    chk("lh_last_half_err", 32'(e), 0);
    for (int n = 0; n < 300; n++) begin
      i = n % 2;
      r = $urandom_range(0, 9);
      a = r < 5 ? BASE + $urandom_range(0, 255) : r < 9 ? LIMIT - 32'h100 + $urandom_range(0, 255) :
          ($urandom_range(0, 1) ? LIMIT + 32'($urandom_range(0, 7)) : $urandom);
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: f3 = B;
        1: f3 = H;
        2: f3 = W;
        3: f3 = BU;
        default: f3 = HU;
      endcase
      if (r == 9) f3 = 3'($urandom_range(6, 7));
      if ($urandom_range(0, 1) == 1) a = a & ~32'(f3[1:0] == 2'b00 ? 0 : f3[1:0] == 2'b01 ? 1 : 3);
      txn(i, 1'($urandom), f3, a, $urandom, $urandom_range(0, 3), rd, e, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    txn(0, 0, W, BASE, 0, 0, rd, e, lat);
    req_valid[0] = 1;
    req_we[0] = 0;
    req_funct3[0] = W;
    req_addr[0] = BASE;
    @(posedge clk); #1;
    req_valid[0] = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rst_wait_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_wait_req_ready", 32'(req_ready[0]), 1);
    for (int n = 0; n < 6; n++) begin
      a = BASE + 32'(4 * $urandom_range(0, 63));
      d = $urandom;
      txn(1, 1, W, a, d, 0, rd, e, lat);
      chk("l1_sw_latency", lat, 1);
      txn(1, 0, W, a, 0, 0, rd, e, lat);
      chk("l1_lw_data", rd, d);
      chk("l1_lw_latency", lat, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
